rob_mc: RTL and testbench

Parametrised reorder buffer and the successor to the current single-commit ROB. It sits between decoder (issue), RS/LSB (write-back), regfile (commit/dependency tags) and insfetch (branch feedback, redirect). New behaviour over the current ROB:
- configurable depth and write-back port count;
- up to two in-order commits per cycle;
- an explicit occupancy counter;
- optional JALR target verification.

---
 rtl/rob_pkg.sv | 30 +++
 rtl/rob_query_mux.sv | 42 ++++
 rtl/rob_mc.sv | 234 +++++++++++++++++++++++
 tb/tb_rob_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the rob_mc reorder buffer.
//   - ins_type_e    : instruction class stored per entry (S/R/B/J); bit 0 set => writes rd
//   - Def*          : default DEPTH / NUM_WB / FULL_MARGIN for the top and sub-modules
//   - commits_alone : classes that may only retire from commit slot 0
// Optional feature macro: ROB_JALR_CHECK_EN (J entries also retire alone so their target
// can be verified from slot 0).
package rob_pkg;

  typedef enum logic [1:0] {
    TypeS = 2'd0,
    TypeR = 2'd1,
    TypeB = 2'd2,
    TypeJ = 2'd3
  } ins_type_e;

  localparam int unsigned DefDepth      = 16;
  localparam int unsigned DefNumWb      = 2;
  localparam int unsigned DefFullMargin = 2;

  // Redirect-capable entries only resolve from slot 0, so they never retire in slot 1 and
  // nothing retires behind them in the same cycle.
  function automatic logic commits_alone(ins_type_e t);
`ifdef ROB_JALR_CHECK_EN
    return (t == TypeB) || (t == TypeJ);
`else
    return t == TypeB;
`endif
  endfunction

endpackage

// File: rtl/rob_query_mux.sv
// rob_query_mux: operand lookup for one tag.
//   q_id_i      : queried tag
//   done_i      : per-entry done flags (already cleared for free entries)
//   val_i       : per-entry stored values, entry i at [i*32 +: 32]
//   wb_valid_i  : per-port write-back strobes
//   wb_id_i     : per-port tags, port p at [p*IDW +: IDW]
//   wb_val_i    : per-port values, port p at [p*32 +: 32]
//   avail_o     : operand available (stored or same-cycle bypass)
//   val_o       : operand value; stored value first, else lowest matching port
module rob_query_mux
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned IDW    = $clog2(DEPTH),
  parameter int unsigned NUM_WB = DefNumWb
) (
  input  logic [IDW-1:0]        q_id_i,
  input  logic [DEPTH-1:0]      done_i,
  input  logic [DEPTH*32-1:0]   val_i,
  input  logic [NUM_WB-1:0]     wb_valid_i,
  input  logic [NUM_WB*IDW-1:0] wb_id_i,
  input  logic [NUM_WB*32-1:0]  wb_val_i,
  output logic                  avail_o,
  output logic [31:0]           val_o
);

  always_comb begin
    avail_o = done_i[q_id_i];
    val_o   = val_i[q_id_i*32 +: 32];
    if (!done_i[q_id_i]) begin
      val_o = '0;
      // Walk downward so the lowest matching port is the last assignment.
      for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_id_i[p*IDW +: IDW] == q_id_i)) begin
          avail_o = 1'b1;
          val_o   = wb_val_i[p*32 +: 32];
        end
      end
    end
  end

endmodule

// File: rtl/rob_mc.sv
// rob_mc: parametrised reorder buffer with up to two in-order commits per cycle.
//   clk_in, rst_n_in, rdy_in     : clock, async active-low reset, global enable
//   flush_out, flush_pc          : one-cycle redirect pulse and its target
//   rob_empty, rob_full, rob_count : occupancy status
//   is_ins, ins_*, another_addr  : issue bundle; rob_free_id is the tag it receives
//   rob_head_id                  : oldest tag (store gating)
//   wb_valid, wb_id, wb_val      : NUM_WB write-back ports
//   cm_valid, cm_rd, cm_val, cm_id : commit slots 0/1 (slot 0 in the low field)
//   set_dep_id, set_dep_Q        : rename update for the issuing instruction
//   q_id_*, q_avail_*, q_val_*   : two operand queries with write-back bypass
//   bp_valid, bp_pc_part, bp_taken : branch outcome to the predictor
// Optional feature macro: ROB_JALR_CHECK_EN (verify JALR targets at commit).
module rob_mc
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned IDW         = $clog2(DEPTH),
  parameter int unsigned NUM_WB      = DefNumWb,
  parameter int unsigned FULL_MARGIN = DefFullMargin
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  output logic                  flush_out,
  output logic [31:0]           flush_pc,
  output logic                  rob_empty,
  output logic                  rob_full,
  output logic [IDW:0]          rob_count,
  input  logic                  is_ins,
  input  logic [31:0]           ins_pc,
  input  logic [4:0]            ins_rd,
  input  logic [1:0]            ins_type,
  input  logic                  ins_pred_jmp,
  input  logic [31:0]           another_addr,
  output logic [IDW-1:0]        rob_free_id,
  output logic [IDW-1:0]        rob_head_id,
  input  logic [NUM_WB-1:0]     wb_valid,
  input  logic [NUM_WB*IDW-1:0] wb_id,
  input  logic [NUM_WB*32-1:0]  wb_val,
  output logic [1:0]            cm_valid,
  output logic [9:0]            cm_rd,
  output logic [63:0]           cm_val,
  output logic [2*IDW-1:0]      cm_id,
  output logic [4:0]            set_dep_id,
  output logic [IDW-1:0]        set_dep_Q,
  input  logic [IDW-1:0]        q_id_1,
  input  logic [IDW-1:0]        q_id_2,
  output logic                  q_avail_1,
  output logic                  q_avail_2,
  output logic [31:0]           q_val_1,
  output logic [31:0]           q_val_2,
  output logic                  bp_valid,
  output logic [7:0]            bp_pc_part,
  output logic                  bp_taken
);

  // Entry storage
  logic [DEPTH-1:0]       busy_q, busy_d;
  logic [DEPTH-1:0]       done_q, done_d;
  logic [DEPTH-1:0][31:0] val_q, val_d;
  logic [DEPTH-1:0][31:0] alt_q;
  logic [DEPTH-1:0]       pred_q;
  ins_type_e              type_q [DEPTH];
  logic [4:0]             rd_q   [DEPTH];
  logic [7:0]             pc_q   [DEPTH];

  logic [IDW-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [IDW:0]   count_q, count_d;
  logic           flush_q, flush_d;
  logic [31:0]    flush_pc_q, flush_pc_d;

  logic        issue, c0, c1, head_is_b;
  logic        br_miss, jalr_miss, redirect;
  logic [31:0] redirect_pc;

  // Only pc[8:1] feeds the predictor.
  logic unused_pc;
  assign unused_pc = ^{ins_pc[31:9], ins_pc[0]};

  assign head1     = head_q + IDW'(1);
  assign head_is_b = type_q[head_q] == TypeB;

  // Accept only into a physically free slot; registered busy keeps a full ROB that is
  // committing this cycle from accepting.
  assign issue = rdy_in && is_ins && !flush_q && !busy_q[tail_q];
  assign c0    = rdy_in && !flush_q && busy_q[head_q] && done_q[head_q];
  assign c1    = c0 && busy_q[head1] && done_q[head1] &&
                 !commits_alone(type_q[head_q]) && !commits_alone(type_q[head1]);

  assign br_miss = c0 && head_is_b && (val_q[head_q][0] != pred_q[head_q]);
`ifdef ROB_JALR_CHECK_EN
  // J entries hold the predicted target in alt and the resolved target in val.
  assign jalr_miss = c0 && (type_q[head_q] == TypeJ) && (val_q[head_q] != alt_q[head_q]);
`else
  assign jalr_miss = 1'b0;
`endif
  assign redirect    = br_miss || jalr_miss;
  assign redirect_pc = br_miss ? alt_q[head_q] : val_q[head_q];

  always_comb begin
    busy_d     = busy_q;
    done_d     = done_q;
    val_d      = val_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy_in) begin
      if (flush_q) begin
        busy_d  = '0;
        done_d  = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        flush_d = 1'b0;
      end else begin
        // Later ports overwrite earlier ones on a (illegal) shared tag.
        for (int p = 0; p < NUM_WB; p++) begin
          if (wb_valid[p] && busy_q[wb_id[p*IDW +: IDW]]) begin
            done_d[wb_id[p*IDW +: IDW]] = 1'b1;
            val_d[wb_id[p*IDW +: IDW]]  = wb_val[p*32 +: 32];
          end
        end
        if (c0) begin
          busy_d[head_q] = 1'b0;
          done_d[head_q] = 1'b0;
        end
        if (c1) begin
          busy_d[head1] = 1'b0;
          done_d[head1] = 1'b0;
        end
        if (issue) begin
          busy_d[tail_q] = 1'b1;
          done_d[tail_q] = 1'b0;
          tail_d         = tail_q + IDW'(1);
        end
        head_d  = head_q + IDW'(c0) + IDW'(c1);
        count_d = count_q + (IDW+1)'(issue) - (IDW+1)'(c0) - (IDW+1)'(c1);
        if (redirect) begin
          flush_d    = 1'b1;
          flush_pc_d = redirect_pc;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q     <= '0;
      done_q     <= '0;
      val_q      <= '0;
      alt_q      <= '0;
      pred_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= TypeS;
        rd_q[i]   <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      val_q      <= val_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      if (issue) begin
        type_q[tail_q] <= ins_type_e'(ins_type);
        rd_q[tail_q]   <= ins_rd;
        pred_q[tail_q] <= ins_pred_jmp;
        alt_q[tail_q]  <= another_addr;
        pc_q[tail_q]   <= ins_pc[8:1];
      end
    end
  end

  assign flush_out   = flush_q;
  assign flush_pc    = flush_pc_q;
  assign rob_count   = count_q;
  assign rob_empty   = count_q == '0;
  assign rob_full    = busy_q[tail_q] || (count_q >= (IDW+1)'(DEPTH - FULL_MARGIN));
  assign rob_free_id = tail_q;
  assign rob_head_id = head_q;
  assign set_dep_id  = ins_type[0] ? ins_rd : 5'd0;
  assign set_dep_Q   = tail_q;

  assign cm_valid = {c1, c0};
  assign cm_id    = {head1, head_q};
  assign cm_val   = {val_q[head1], val_q[head_q]};
  assign cm_rd    = {(c1 && type_q[head1][0])  ? rd_q[head1]  : 5'd0,
                     (c0 && type_q[head_q][0]) ? rd_q[head_q] : 5'd0};

  assign bp_valid   = c0 && head_is_b;
  assign bp_pc_part = pc_q[head_q];
  assign bp_taken   = val_q[head_q][0];

  rob_query_mux #(
    .DEPTH  (DEPTH),
    .IDW    (IDW),
    .NUM_WB (NUM_WB)
  ) u_query_1 (
    .q_id_i     (q_id_1),
    .done_i     (done_q),
    .val_i      (val_q),
    .wb_valid_i (wb_valid),
    .wb_id_i    (wb_id),
    .wb_val_i   (wb_val),
    .avail_o    (q_avail_1),
    .val_o      (q_val_1)
  );

  rob_query_mux #(
    .DEPTH  (DEPTH),
    .IDW    (IDW),
    .NUM_WB (NUM_WB)
  ) u_query_2 (
    .q_id_i     (q_id_2),
    .done_i     (done_q),
    .val_i      (val_q),
    .wb_valid_i (wb_valid),
    .wb_id_i    (wb_id),
    .wb_val_i   (wb_val),
    .avail_o    (q_avail_2),
    .val_o      (q_val_2)
  );

endmodule

// File: tb/tb_rob_mc.sv
// Bench for rob_mc (DEPTH 16, NUM_WB 2): directed scenarios, then a randomized run whose
// commits are checked by a monitor against an in-order reference queue.
module tb_rob_mc;

  localparam int DEPTH = 16;
  localparam int IDW   = 4;

  logic              clk_in = 1'b0;
  logic              rst_n_in, rdy_in;
  logic              flush_out, rob_empty, rob_full;
  logic [31:0]       flush_pc;
  logic [IDW:0]      rob_count;
  logic              is_ins, ins_pred_jmp;
  logic [31:0]       ins_pc, another_addr;
  logic [4:0]        ins_rd;
  logic [1:0]        ins_type;
  logic [IDW-1:0]    rob_free_id, rob_head_id;
  logic [1:0]        wb_valid;
  logic [2*IDW-1:0]  wb_id;
  logic [63:0]       wb_val;
  logic [1:0]        cm_valid;
  logic [9:0]        cm_rd;
  logic [63:0]       cm_val;
  logic [2*IDW-1:0]  cm_id;
  logic [4:0]        set_dep_id;
  logic [IDW-1:0]    set_dep_Q, q_id_1, q_id_2;
  logic              q_avail_1, q_avail_2, bp_valid, bp_taken;
  logic [31:0]       q_val_1, q_val_2;
  logic [7:0]        bp_pc_part;

  rob_mc #(.DEPTH(DEPTH), .IDW(IDW), .NUM_WB(2), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .flush_out(flush_out), .flush_pc(flush_pc),
    .rob_empty(rob_empty), .rob_full(rob_full), .rob_count(rob_count),
    .is_ins(is_ins), .ins_pc(ins_pc), .ins_rd(ins_rd), .ins_type(ins_type),
    .ins_pred_jmp(ins_pred_jmp), .another_addr(another_addr),
    .rob_free_id(rob_free_id), .rob_head_id(rob_head_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_id(cm_id),
    .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
    .q_id_1(q_id_1), .q_id_2(q_id_2),
    .q_avail_1(q_avail_1), .q_avail_2(q_avail_2), .q_val_1(q_val_1), .q_val_2(q_val_2),
    .bp_valid(bp_valid), .bp_pc_part(bp_pc_part), .bp_taken(bp_taken)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for the random phase: instructions in program order.
  typedef struct {
    int         tag;
    logic [4:0] rd;
  } exp_t;
  exp_t        exp_q[$];
  bit          mdone [DEPTH];
  logic [31:0] mval  [DEPTH];
  int          mcount = 0;
  bit          mon_en = 1'b0;

  always @(negedge clk_in) begin
    if (mon_en) begin
      int   n;
      exp_t e;
      n = 0;
      if (rdy_in && exp_q.size() > 0 && mdone[exp_q[0].tag]) begin
        n = 1;
        if (exp_q.size() > 1 && mdone[exp_q[1].tag]) n = 2;
      end
      chk("rnd_cm_valid", cm_valid, (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11);
      for (int s = 0; s < n; s++) begin
        e = exp_q.pop_front();
        chk("rnd_cm_id", cm_id[s*IDW +: IDW], e.tag);
        chk("rnd_cm_rd", cm_rd[s*5 +: 5], e.rd);
        chk("rnd_cm_val", cm_val[s*32 +: 32], mval[e.tag]);
      end
      chk("rnd_count", rob_count, mcount);
      chk("rnd_full", rob_full, mcount >= DEPTH - 2);
      chk("rnd_empty", rob_empty, mcount == 0);
      if (rdy_in) begin
        for (int p = 0; p < 2; p++) begin
          if (wb_valid[p]) begin
            mdone[wb_id[p*IDW +: IDW]] = 1'b1;
            mval[wb_id[p*IDW +: IDW]]  = wb_val[p*32 +: 32];
          end
        end
        mcount = mcount + int'(is_ins) - n;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    is_ins = 1'b0; ins_pc = '0; ins_rd = '0; ins_type = '0; ins_pred_jmp = 1'b0;
    another_addr = '0; wb_valid = '0; wb_id = '0; wb_val = '0; q_id_1 = '0; q_id_2 = '0;
  endtask

  task automatic drv_issue(input logic [1:0] t, input logic [4:0] rd, input logic pj,
                           input logic [31:0] alt, input logic [31:0] pc);
    is_ins = 1'b1; ins_type = t; ins_rd = rd; ins_pred_jmp = pj;
    another_addr = alt; ins_pc = pc;
  endtask

  task automatic do_reset();
    idle();
    rdy_in   = 1'b1;
    rst_n_in = 1'b0;
    #7;
    rst_n_in = 1'b1;
    step();
  endtask

  int pend[$];
  int new_tag, drv_tail, k, tg;

  initial begin
    // Reset values, then three R ops committed two-then-one.
    do_reset();
    chk("rst_count", rob_count, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_flush", flush_out, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_cm_valid", cm_valid, 0);
    drv_issue(2'd1, 5'd1, 1'b0, 0, 0);
    #1;
    chk("t1_dep_id", set_dep_id, 1);
    chk("t1_dep_q", set_dep_Q, 0);
    step();
    drv_issue(2'd1, 5'd2, 1'b0, 0, 0); step();
    drv_issue(2'd1, 5'd3, 1'b0, 0, 0); step();
    idle();
    chk("t1_count3", rob_count, 3);
    chk("t1_free_id", rob_free_id, 3);
    wb_valid = 2'b11; wb_id = {4'd1, 4'd2}; wb_val = {32'd20, 32'd30};
    step(); idle();
    chk("t1_no_commit", cm_valid, 2'b00);
    wb_valid = 2'b01; wb_id = {4'd0, 4'd0}; wb_val = {32'd0, 32'd10};
    step(); idle();
    chk("t1_dual_valid", cm_valid, 2'b11);
    chk("t1_dual_rd", cm_rd, {5'd2, 5'd1});
    chk("t1_dual_val", cm_val, {32'd20, 32'd10});
    chk("t1_dual_id", cm_id, {4'd1, 4'd0});
    step();
    chk("t1_single_valid", cm_valid, 2'b01);
    chk("t1_single_rd", cm_rd[4:0], 3);
    chk("t1_single_val", cm_val[31:0], 30);
    chk("t1_count1", rob_count, 1);
    step();
    chk("t1_count0", rob_count, 0);
    chk("t1_empty", rob_empty, 1);

    // Same-cycle bypass and stored-over-bypass priority.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv_issue(2'd1, 5'(i + 1), 1'b0, 0, 0);
      step();
    end
    idle();
    wb_valid = 2'b11; wb_id = {4'd5, 4'd3}; wb_val = {32'h0000_abcd, 32'h0000_1111};
    q_id_1 = 4'd5; q_id_2 = 4'd4;
    #1;
    chk("t2_byp_avail", q_avail_1, 1);
    chk("t2_byp_val", q_val_1, 32'h0000_abcd);
    chk("t2_not_avail", q_avail_2, 0);
    step(); idle();
    wb_valid = 2'b01; wb_id = {4'd0, 4'd5}; wb_val = {32'd0, 32'h0000_2222};
    q_id_1 = 4'd5; q_id_2 = 4'd3;
    #1;
    chk("t2_stored_first", q_val_1, 32'h0000_abcd);
    chk("t2_stored_avail", q_avail_2, 1);
    chk("t2_stored_val", q_val_2, 32'h0000_1111);

    // Mispredicted branch: flush pulse, concurrent issue ignored.
    do_reset();
    drv_issue(2'd2, 5'd0, 1'b1, 32'h100, 32'h1fe); step();
    drv_issue(2'd1, 5'd4, 1'b0, 0, 32'h200); step();
    idle();
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'd7, 32'd0};
    step(); idle();
    chk("t3_cm_valid", cm_valid, 2'b01);
    chk("t3_bp_valid", bp_valid, 1);
    chk("t3_bp_taken", bp_taken, 0);
    chk("t3_bp_pc", bp_pc_part, 8'hff);
    step();
    drv_issue(2'd1, 5'd9, 1'b0, 0, 0);
    #1;
    chk("t3_flush", flush_out, 1);
    chk("t3_flush_pc", flush_pc, 32'h100);
    chk("t3_no_commit", cm_valid, 0);
    chk("t3_count1", rob_count, 1);
    step(); idle();
    chk("t3_flush_end", flush_out, 0);
    chk("t3_count0", rob_count, 0);
    chk("t3_empty", rob_empty, 1);
    chk("t3_tail0", rob_free_id, 0);

    // Branch behind a done R: retires alone in the following cycle.
    do_reset();
    drv_issue(2'd1, 5'd5, 1'b0, 0, 0); step();
    drv_issue(2'd2, 5'd0, 1'b0, 32'h300, 32'h40); step();
    idle();
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'd0, 32'd1};
    step(); idle();
    chk("t4_r_only", cm_valid, 2'b01);
    chk("t4_r_rd", cm_rd[4:0], 5);
    chk("t4_no_bp", bp_valid, 0);
    step();
    chk("t4_b_valid", cm_valid, 2'b01);
    chk("t4_b_bp", bp_valid, 1);
    chk("t4_b_taken", bp_taken, 0);
    chk("t4_b_pc", bp_pc_part, 8'h20);
    chk("t4_b_rd", cm_rd, 0);
    step();
    chk("t4_no_flush", flush_out, 0);
    chk("t4_empty", rob_empty, 1);

    // Fill to DEPTH: full threshold, wrap, refused issue.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drv_issue(2'd1, 5'd1, 1'b0, 0, 0);
      step();
      chk("t5_full_thresh", rob_full, (i + 1) >= DEPTH - 2);
    end
    drv_issue(2'd1, 5'd2, 1'b0, 0, 0); step();
    idle();
    chk("t5_count16", rob_count, 16);
    chk("t5_tail_wrap", rob_free_id, 0);
    chk("t5_head0", rob_head_id, 0);
    chk("t5_not_empty", rob_empty, 0);
    wb_valid = 2'b01; wb_id = '0; wb_val = {32'd0, 32'd5};
    step(); idle();
    chk("t5_commit", cm_valid, 2'b01);
    step();
    chk("t5_count15", rob_count, 15);
    chk("t5_full15", rob_full, 1);
    chk("t5_head1", rob_head_id, 1);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv_issue(2'd1, 5'd7, 1'b0, 0, 0);
      step();
    end
    idle();
    wb_valid = 2'b01; wb_id = '0; wb_val = {32'd0, 32'd9};
    step(); idle();
    chk("t6_pre", cm_valid, 2'b01);
    rst_n_in = 1'b0;
    #1;
    chk("t6_count", rob_count, 0);
    chk("t6_empty", rob_empty, 1);
    chk("t6_cm_valid", cm_valid, 0);
    chk("t6_tail", rob_free_id, 0);
    #2;
    rst_n_in = 1'b1;
    step();

    // rdy_in low freezes state and masks commit.
    do_reset();
    drv_issue(2'd1, 5'd6, 1'b0, 0, 0); step();
    idle();
    wb_valid = 2'b01; wb_id = '0; wb_val = {32'd0, 32'h55};
    step(); idle();
    rdy_in = 1'b0;
    #1;
    chk("t7_masked", cm_valid, 0);
    step();
    chk("t7_frozen", rob_count, 1);
    rdy_in = 1'b1;
    #1;
    chk("t7_commit", cm_valid, 2'b01);
    chk("t7_val", cm_val[31:0], 32'h55);
    step();
    chk("t7_count0", rob_count, 0);

    // Randomized run against the reference queue.
    do_reset();
    exp_q.delete();
    pend.delete();
    mcount   = 0;
    new_tag  = -1;
    drv_tail = 0;
    mon_en   = 1'b1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc >= 600 && exp_q.size() == 0 && pend.size() == 0 && new_tag < 0) break;
      if (new_tag >= 0) begin
        pend.push_back(new_tag);
        new_tag = -1;
      end
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      if (rdy_in) begin
        if (cyc < 600 && !rob_full && $urandom_range(0, 2) != 0) begin
          exp_t e;
          logic [1:0] t;
          logic [4:0] rd;
          t  = $urandom_range(0, 1) ? 2'd1 : 2'd0;
          rd = 5'($urandom_range(0, 31));
          drv_issue(t, rd, 1'b0, $urandom, $urandom);
          mdone[drv_tail] = 1'b0;
          e.tag = drv_tail;
          e.rd  = t[0] ? rd : 5'd0;
          exp_q.push_back(e);
          new_tag  = drv_tail;
          drv_tail = (drv_tail + 1) % DEPTH;
        end
        for (int p = 0; p < 2; p++) begin
          if (pend.size() > 0 && $urandom_range(0, 1) != 0) begin
            k  = int'($urandom_range(0, pend.size() - 1));
            tg = pend[k];
            pend.delete(k);
            wb_valid[p]            = 1'b1;
            wb_id[p*IDW +: IDW]    = 4'(tg);
            wb_val[p*32 +: 32]     = $urandom;
          end
        end
      end
      step();
    end
    mon_en = 1'b0;
    chk("rnd_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
